handshake_buffer: RTL and testbench
===================================

// Module: handshake_buffer
// PURPOSE
//   Multi-channel response capture buffer for stalled pipeline stages.
//   While the pipeline is stalled, each bus channel (e.g. ibus, dbus) can return data
//   via data_ok; that data is queued in a per-channel FIFO and held for the stage.
//   Provides per-channel finish/head data and an aggregate all_done used by hazard logic
//   to release the stall.
// PARAMETERS
//   NCH     2   number of independent response channels
//   DATA_W  64  width of each channel's read data
//   DEPTH   2   FIFO entries per channel (>=1); CNT_W = $clog2(DEPTH+1)
// PORTS
//   clk              in   1             clock
//   reset            in   1             synchronous, active-high reset
//   handshake_stall  in   1             pipeline stalled; enables capture, blocks consume
//   flush            in   1             discard all queued entries, all channels
//   req_mask         in   NCH           channels the current stage waits on
//   data_ok          in   NCH           per-channel response valid (1-cycle pulse)
//   read_data        in   NCH*DATA_W    per-channel response data, ch i at [i*DATA_W +: DATA_W]
//   finish           out  NCH           channel has >=1 queued entry
//   store_data       out  NCH*DATA_W    FIFO head per channel, '0 when empty
//   count            out  NCH*CNT_W     queued entries per channel
//   overflow         out  NCH           sticky: response dropped because FIFO full
//   all_done         out  1             &(finish | ~req_mask)
// BEHAVIOUR
//   - Reset: all FIFOs empty, rd/wr pointers 0, finish=0, store_data='0, count=0,
//     overflow=0; all_done = &(~req_mask), so 1 when req_mask=0.
//   - Channels are fully independent; only stall/flush/reset are shared.
//   - Priority per channel, per cycle: reset > flush > push/pop.
//   - Push: handshake_stall=1 & data_ok[i]=1 & count[i]<DEPTH -> enqueue read_data[i];
//     visible on finish/store_data the next cycle (1-cycle latency).
//   - Full: handshake_stall=1 & data_ok[i]=1 & count[i]==DEPTH -> data dropped,
//     overflow[i] <= 1; cleared only by reset (not by flush).
//   - Pop: handshake_stall=0 & count[i]>0 -> dequeue one entry. One pop per channel per
//     unstalled cycle; successive entries are consumed by successive advances.
//   - data_ok while handshake_stall=0 is ignored; no push and no overflow.
//   - Push and pop cannot coincide, because stall selects one or the other.
//   - Pointers wrap modulo DEPTH; non-power-of-2 DEPTH is legal (explicit wrap compare).
//   - flush=1: count, pointers -> 0 next cycle; data_ok in the same cycle is discarded.
//   - reset mid-burst: all state cleared next edge regardless of other inputs.
//   - store_data is combinational from the head entry, forced to '0 when count==0.
//   - count, finish and all_done are combinational from registered state (plus req_mask).
// CONFIGURATION
//   HSBUF_BYPASS_EN defined: when count[i]==0, handshake_stall=1 and data_ok[i]=1,
//     finish[i]=1 and store_data[i]=read_data[i] in the same cycle (combinational bypass),
//     all_done follows. The entry is still enqueued as normal, so the next cycle is
//     identical to the non-bypass build.
//   Undefined: strictly registered; outputs reflect only stored entries (1-cycle latency).
// TESTING
//   1 reset=1 for 2 cycles, then idle, req_mask=2'b00 -> finish=0, count=0,
//     store_data=0, overflow=0, all_done=1.
//   2 stall=1, req_mask=2'b11, data_ok[0] with 64'hA5 at t0, data_ok[1] with 64'h5A at t3
//     -> finish=01 from t1, all_done=0 until t4, then 1; stall=0 for 1 cycle -> both pop,
//     finish=00.
//   3 DEPTH=2, stall=1, ch0 pushes 1,2,3 on consecutive cycles -> count=2,
//     overflow[0]=1, head=1; stall=0 two cycles -> store_data 1 then 2, then empty.
//   4 stall=0 while data_ok[1]=1 with 64'hFF -> count[1] stays 0, overflow[1] stays 0.
//   5 ch0 holds 2 entries, overflow=1; flush=1 together with data_ok[0]
//     -> count=0 next cycle, data dropped, overflow still 1; reset -> overflow=0.
//   6 HSBUF_BYPASS_EN: empty ch0, stall=1, data_ok with 64'h1234 -> finish[0]=1 and
//     store_data=64'h1234 same cycle; without macro both appear one cycle later.

Source files
------------

// File: rtl/handshake_buffer_if.sv
// ============================================================================
// Module      : handshake_buffer_if
// Description : Bus bundle for handshake_buffer: stall/flush control, per-channel
//               response inputs and the captured finish/head/count/overflow outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface handshake_buffer_if #(
    parameter int NCH    = 2,
    parameter int DATA_W = 64,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) ();
    logic                    handshake_stall;
    logic                    flush;
    logic [NCH-1:0]          req_mask;
    logic [NCH-1:0]          data_ok;
    logic [NCH*DATA_W-1:0]   read_data;
    logic [NCH-1:0]          finish;
    logic [NCH*DATA_W-1:0]   store_data;
    logic [NCH*CNT_W-1:0]    count;
    logic [NCH-1:0]          overflow;
    logic                    all_done;

    modport master (
        output handshake_stall, flush, req_mask, data_ok, read_data,
        input  finish, store_data, count, overflow, all_done
    );

    modport slave (
        input  handshake_stall, flush, req_mask, data_ok, read_data,
        output finish, store_data, count, overflow, all_done
    );
endinterface

`default_nettype wire

// File: rtl/handshake_buffer.sv
// ============================================================================
// Module      : handshake_buffer
// Description : Per-channel response FIFOs that hold bus data returned while the
//               pipeline is stalled; one entry per channel drains per unstalled cycle.
//               Define HSBUF_BYPASS_EN to expose a response on an empty channel in
//               the same cycle it arrives.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module handshake_buffer #(
    parameter int NCH    = 2,
    parameter int DATA_W = 64,
    parameter int DEPTH  = 2
) (
    input  wire logic           clk,
    input  wire logic           reset,
    handshake_buffer_if.slave   bus
);

    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Explicit wrap so that non-power-of-two depths index correctly.
    function automatic logic [c_PTR_W-1:0] f_ptr_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(DEPTH - 1)) ? '0 : p + c_PTR_W'(1);
    endfunction

    logic [NCH-1:0]     w_finish;
    logic [NCH-1:0]     w_ovf;
    logic [DATA_W-1:0]  w_head [NCH];
    logic [c_CNT_W-1:0] w_cnt  [NCH];

    generate
        for (genvar g = 0; g < NCH; g++) begin : g_ch
            logic [DATA_W-1:0]  r_mem [DEPTH];
            logic [c_PTR_W-1:0] r_rd_ptr;
            logic [c_PTR_W-1:0] r_wr_ptr;
            logic [c_CNT_W-1:0] r_cnt;
            logic               r_ovf;
            logic               w_empty;
            logic               w_full;
            logic               w_push;
            logic               w_pop;
            logic               w_drop;
            logic               w_byp;
            logic [DATA_W-1:0]  w_wdata;

            assign w_wdata = bus.read_data[g*DATA_W +: DATA_W];
            assign w_empty = (r_cnt == '0);
            assign w_full  = (r_cnt == c_CNT_W'(DEPTH));
            // Stall selects capture vs. drain, so push and pop never coincide.
            assign w_push  = bus.handshake_stall & bus.data_ok[g] & ~w_full & ~bus.flush;
            assign w_drop  = bus.handshake_stall & bus.data_ok[g] &  w_full & ~bus.flush;
            assign w_pop   = ~bus.handshake_stall & ~w_empty & ~bus.flush;

`ifdef HSBUF_BYPASS_EN
            assign w_byp   = w_empty & bus.handshake_stall & bus.data_ok[g];
`else
            assign w_byp   = 1'b0;
`endif

            always_ff @(posedge clk) begin
                if (w_push) begin
                    r_mem[r_wr_ptr] <= w_wdata;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_rd_ptr <= '0;
                    r_wr_ptr <= '0;
                    r_cnt    <= '0;
                    r_ovf    <= 1'b0;
                end else if (bus.flush) begin
                    // Overflow is sticky across flush; only reset clears it.
                    r_rd_ptr <= '0;
                    r_wr_ptr <= '0;
                    r_cnt    <= '0;
                end else begin
                    if (w_push) begin
                        r_wr_ptr <= f_ptr_inc(r_wr_ptr);
                        r_cnt    <= r_cnt + c_CNT_W'(1);
                    end
                    if (w_pop) begin
                        r_rd_ptr <= f_ptr_inc(r_rd_ptr);
                        r_cnt    <= r_cnt - c_CNT_W'(1);
                    end
                    if (w_drop) begin
                        r_ovf    <= 1'b1;
                    end
                end
            end

            assign w_finish[g] = ~w_empty | w_byp;
            assign w_ovf[g]    = r_ovf;
            assign w_cnt[g]    = r_cnt;
            assign w_head[g]   = ~w_empty ? r_mem[r_rd_ptr] : (w_byp ? w_wdata : '0);
        end
    endgenerate

    always_comb begin
        bus.store_data = '0;
        bus.count      = '0;
        for (int i = 0; i < NCH; i++) begin
            bus.store_data[i*DATA_W +: DATA_W] = w_head[i];
            bus.count[i*c_CNT_W +: c_CNT_W]    = w_cnt[i];
        end
    end

    assign bus.finish   = w_finish;
    assign bus.overflow = w_ovf;
    assign bus.all_done = &(w_finish | ~bus.req_mask);

endmodule

`default_nettype wire

// File: tb/tb_handshake_buffer.sv
// ============================================================================
// Module      : tb_handshake_buffer
// Description : Scoreboard bench for handshake_buffer (NCH=2, DATA_W=64, DEPTH=2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_handshake_buffer;

    localparam int c_NCH   = 2;
    localparam int c_DW    = 64;
    localparam int c_DEPTH = 2;
    localparam int c_CW    = $clog2(c_DEPTH + 1);

    logic clk;
    logic reset;

    handshake_buffer_if #(.NCH(c_NCH), .DATA_W(c_DW), .DEPTH(c_DEPTH)) bus ();

    handshake_buffer #(.NCH(c_NCH), .DATA_W(c_DW), .DEPTH(c_DEPTH)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [63:0] q0 [$];
    logic [63:0] q1 [$];
    logic [1:0]  m_ovf;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic stall, input logic fl, input logic [1:0] dok,
                         input logic [63:0] d0, input logic [63:0] d1);
        bus.handshake_stall = stall;
        bus.flush           = fl;
        bus.data_ok         = dok;
        bus.read_data       = {d1, d0};
    endtask

    task automatic check_outputs(input string tag);
        logic [1:0]  fin;
        logic [63:0] head [2];
        int          sz   [2];
        sz[0]   = q0.size();
        sz[1]   = q1.size();
        head[0] = (sz[0] != 0) ? q0[0] : 64'h0;
        head[1] = (sz[1] != 0) ? q1[0] : 64'h0;
        fin     = {sz[1] != 0, sz[0] != 0};
`ifdef HSBUF_BYPASS_EN
        for (int c = 0; c < 2; c++) begin
            if (sz[c] == 0 && bus.handshake_stall && bus.data_ok[c]) begin
                fin[c]  = 1'b1;
                head[c] = bus.read_data[c*64 +: 64];
            end
        end
`endif
        for (int c = 0; c < 2; c++) begin
            check($sformatf("%s_cnt%0d", tag, c), 64'(bus.count[c*c_CW +: c_CW]), 64'(sz[c]));
            check($sformatf("%s_fin%0d", tag, c), 64'(bus.finish[c]), 64'(fin[c]));
            check($sformatf("%s_data%0d", tag, c), bus.store_data[c*64 +: 64], head[c]);
            check($sformatf("%s_ovf%0d", tag, c), 64'(bus.overflow[c]), 64'(m_ovf[c]));
        end
        check($sformatf("%s_alldone", tag), 64'(bus.all_done), 64'(&(fin | ~bus.req_mask)));
    endtask

    task automatic model_edge();
        if (reset) begin
            q0.delete();
            q1.delete();
            m_ovf = 2'b00;
        end else if (bus.flush) begin
            q0.delete();
            q1.delete();
        end else if (bus.handshake_stall) begin
            if (bus.data_ok[0]) begin
                if (q0.size() < c_DEPTH) q0.push_back(bus.read_data[63:0]);
                else m_ovf[0] = 1'b1;
            end
            if (bus.data_ok[1]) begin
                if (q1.size() < c_DEPTH) q1.push_back(bus.read_data[127:64]);
                else m_ovf[1] = 1'b1;
            end
        end else begin
            if (q0.size() != 0) void'(q0.pop_front());
            if (q1.size() != 0) void'(q1.pop_front());
        end
    endtask

    // Inputs are applied 1 time unit after an edge; outputs sampled 2 units later.
    task automatic cycle(input string tag);
        #2;
        check_outputs(tag);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        m_ovf = 2'b00;
        reset = 1'b1;
        bus.req_mask = 2'b00;
        drive(1'b0, 1'b0, 2'b00, 64'h0, 64'h0);
        repeat (2) begin
            @(posedge clk);
            model_edge();
        end
        #1;
        reset = 1'b0;

        // Reset state with nothing requested.
        cycle("rst");
        check("rst_alldone1", 64'(bus.all_done), 64'h1);

        // Two channels answer at different times while stalled.
        bus.req_mask = 2'b11;
        drive(1'b1, 1'b0, 2'b01, 64'hA5, 64'h0);  cycle("t2_0");
        drive(1'b1, 1'b0, 2'b00, 64'h0, 64'h0);   cycle("t2_1");
        check("t2_fin_lit", 64'(bus.finish), 64'h1);
        cycle("t2_2");
        drive(1'b1, 1'b0, 2'b10, 64'h0, 64'h5A);  cycle("t2_3");
        drive(1'b1, 1'b0, 2'b00, 64'h0, 64'h0);   cycle("t2_4");
        check("t2_done_lit", 64'(bus.all_done), 64'h1);
        drive(1'b0, 1'b0, 2'b00, 64'h0, 64'h0);   cycle("t2_pop");
        check("t2_fin_after", 64'(bus.finish), 64'h0);

        // Overflow on a full channel and ordered drain.
        bus.req_mask = 2'b01;
        drive(1'b1, 1'b0, 2'b01, 64'd1, 64'h0);   cycle("t3_p1");
        drive(1'b1, 1'b0, 2'b01, 64'd2, 64'h0);   cycle("t3_p2");
        drive(1'b1, 1'b0, 2'b01, 64'd3, 64'h0);   cycle("t3_p3");
        drive(1'b1, 1'b0, 2'b00, 64'h0, 64'h0);   cycle("t3_full");
        check("t3_ovf_lit", 64'(bus.overflow), 64'h1);
        check("t3_head_lit", bus.store_data[63:0], 64'd1);
        drive(1'b0, 1'b0, 2'b00, 64'h0, 64'h0);   cycle("t3_d1");
        check("t3_head2_lit", bus.store_data[63:0], 64'd2);
        cycle("t3_d2");
        cycle("t3_empty");

        // Responses outside a stall are ignored.
        drive(1'b0, 1'b0, 2'b10, 64'h0, 64'hFF);  cycle("t4_0");
        drive(1'b0, 1'b0, 2'b00, 64'h0, 64'h0);   cycle("t4_1");
        check("t4_cnt1_lit", 64'(bus.count[3:2]), 64'h0);

        // Flush keeps overflow; reset clears it.
        drive(1'b1, 1'b0, 2'b01, 64'h11, 64'h0);  cycle("t5_p1");
        drive(1'b1, 1'b0, 2'b01, 64'h22, 64'h0);  cycle("t5_p2");
        drive(1'b1, 1'b1, 2'b01, 64'h33, 64'h0);  cycle("t5_fl");
        drive(1'b1, 1'b0, 2'b00, 64'h0, 64'h0);   cycle("t5_after");
        check("t5_ovf_lit", 64'(bus.overflow[0]), 64'h1);
        reset = 1'b1;                              cycle("t5_rst");
        reset = 1'b0;                              cycle("t5_rst_after");
        check("t5_ovf_clr_lit", 64'(bus.overflow), 64'h0);

        // Response on an empty channel: same-cycle with bypass, next cycle without.
        drive(1'b1, 1'b0, 2'b01, 64'h1234, 64'h0); cycle("t6_0");
        drive(1'b1, 1'b0, 2'b00, 64'h0, 64'h0);    cycle("t6_1");
        check("t6_data_lit", bus.store_data[63:0], 64'h1234);
        drive(1'b0, 1'b0, 2'b00, 64'h0, 64'h0);    cycle("t6_drain");

        // Random traffic against the scoreboard.
        for (int i = 0; i < 200; i++) begin
            bus.req_mask = 2'($urandom_range(0, 3));
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                  2'($urandom_range(0, 3)),
                  {$urandom, $urandom}, {$urandom, $urandom});
            reset = ($urandom_range(0, 63) == 0);
            cycle("rnd");
        end
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
